// File: rtl/morty_pipeline_ctrl.sv
// Morty pipeline hazard/stall/flush controller with trap drain sequencer.
// Optional perf counters enabled by MORTY_PIPE_PERF_CNT_EN.
module morty_pipeline_ctrl #(
    parameter int NSTAGES = 5,
    parameter int LD_LAT  = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NSTAGES-1:0] stage_stall_req_i,
    input  logic               ld_use_req_i,
    input  logic               branch_req_i,
    input  logic               jump_req_i,
    input  logic               exc_req_i,
    output logic [NSTAGES-1:0] stall_o,
    output logic [NSTAGES-1:0] bubble_o,
    output logic               if_kill_o,
    output logic [1:0]         if_pc_sel_o,
`ifdef MORTY_PIPE_PERF_CNT_EN
    output logic [31:0]        stall_cyc_o,
    output logic [31:0]        flush_cnt_o,
`endif
    output logic               trap_busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_REDIR = 2'd2;

    localparam int EX  = 2;
    localparam int MEM = NSTAGES - 2;
    localparam logic [1:0] LD_INIT = 2'(LD_LAT);
    // EX is only covered by the drain hold when it sits below MEM
    localparam logic EX_IN_DRAIN = (EX <= NSTAGES - 3);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    logic [NSTAGES-1:0] back;
    logic [NSTAGES-1:0] stall_c;
    logic [NSTAGES-1:0] bubble_c;

    logic idle;
    logic drain;
    logic trap_redir;
    logic ex_stall;
    logic redirect;
    logic ld_load;
    logic ld_active;
    logic kill_c;
    logic [1:0] pc_sel_c;

    always_comb begin
        back = '0;
        for (int i = 0; i < NSTAGES; i++) begin
            back[i] = |(stage_stall_req_i >> i);
        end
    end

    assign idle       = (state_q == S_IDLE);
    assign drain      = (state_q == S_DRAIN);
    assign trap_redir = (state_q == S_REDIR);

    assign ex_stall = back[EX] | (drain & EX_IN_DRAIN);

    assign redirect = idle & ~exc_req_i & ~ex_stall
                    & (branch_req_i | jump_req_i);

    assign ld_load = idle & ~exc_req_i & ~ex_stall & ~redirect
                   & ld_use_req_i & (cnt_q == 2'd0);

    assign ld_active = idle & ~redirect
                     & ((cnt_q != 2'd0) | ld_load);

    always_comb begin
        stall_c = back;
        for (int i = 0; i < NSTAGES; i++) begin
            if (ld_active && i <= 1) begin
                stall_c[i] = 1'b1;
            end
            if (drain && i <= NSTAGES - 3) begin
                stall_c[i] = 1'b1;
            end
        end
    end

    always_comb begin
        bubble_c = '0;
        bubble_c[0] = trap_redir;
        for (int i = 1; i < NSTAGES; i++) begin
            bubble_c[i] = stall_c[i-1] & ~stall_c[i];
            if (ld_active && i == EX) begin
                bubble_c[i] = 1'b1;
            end
            if (redirect && i == 1) begin
                bubble_c[i] = 1'b1;
            end
            if (trap_redir && i <= MEM) begin
                bubble_c[i] = 1'b1;
            end
        end
    end

    always_comb begin
        pc_sel_c = 2'b00;
        if (trap_redir) begin
            pc_sel_c = 2'b11;
        end else if (redirect) begin
            pc_sel_c = branch_req_i ? 2'b01 : 2'b10;
        end
    end

    assign kill_c = redirect | trap_redir;

    // Reset is asynchronous, so the combinational view must follow it too
    assign stall_o     = rst_i ? '0   : stall_c;
    assign bubble_o    = rst_i ? '1   : bubble_c;
    assign if_kill_o   = rst_i ? 1'b0 : kill_c;
    assign if_pc_sel_o = rst_i ? 2'b00 : pc_sel_c;
    assign trap_busy_o = rst_i ? 1'b0 : ~idle;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (exc_req_i) begin
                    state_d = stage_stall_req_i[MEM] ? S_DRAIN : S_REDIR;
                end
            end
            S_DRAIN: begin
                if (!stage_stall_req_i[MEM]) begin
                    state_d = S_REDIR;
                end
            end
            S_REDIR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (trap_redir || redirect) begin
            cnt_d = 2'd0;
        end else if (ld_load) begin
            cnt_d = LD_INIT;
        end else if (cnt_q != 2'd0 && !ex_stall) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MORTY_PIPE_PERF_CNT_EN
    logic [31:0] stall_cyc_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cyc_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall_c[0]) begin
                stall_cyc_q <= stall_cyc_q + 32'd1;
            end
            if (kill_c) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cyc_o = stall_cyc_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_morty_pipeline_ctrl.sv
// Directed self-checking bench for morty_pipeline_ctrl (NSTAGES=5, LD_LAT=2).
// Perf counter checks compile only with MORTY_PIPE_PERF_CNT_EN.
module tb_morty_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = '0;
    logic       ld  = 1'b0;
    logic       br  = 1'b0;
    logic       jp  = 1'b0;
    logic       exc = 1'b0;
    logic [4:0] stall;
    logic [4:0] bubble;
    logic       kill;
    logic [1:0] pc_sel;
    logic       busy;
`ifdef MORTY_PIPE_PERF_CNT_EN
    logic [31:0] stall_cyc;
    logic [31:0] flush_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    morty_pipeline_ctrl #(.NSTAGES(5), .LD_LAT(2)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .stage_stall_req_i (req),
        .ld_use_req_i      (ld),
        .branch_req_i      (br),
        .jump_req_i        (jp),
        .exc_req_i         (exc),
        .stall_o           (stall),
        .bubble_o          (bubble),
        .if_kill_o         (kill),
        .if_pc_sel_o       (pc_sel),
`ifdef MORTY_PIPE_PERF_CNT_EN
        .stall_cyc_o       (stall_cyc),
        .flush_cnt_o       (flush_cnt),
`endif
        .trap_busy_o       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [4:0] q,
                         input logic l, input logic b,
                         input logic j, input logic e);
        @(negedge clk);
        rst = r; req = q; ld = l; br = b; jp = j; exc = e;
        #2;
    endtask

    task automatic outs(input string tag, input logic [4:0] s,
                        input logic [4:0] bu, input logic k,
                        input logic [1:0] p, input logic bz);
        chk({tag, ".stall"},  32'(stall),  32'(s));
        chk({tag, ".bubble"}, 32'(bubble), 32'(bu));
        chk({tag, ".kill"},   32'(kill),   32'(k));
        chk({tag, ".pcsel"},  32'(pc_sel), 32'(p));
        chk({tag, ".busy"},   32'(busy),   32'(bz));
    endtask

    initial begin
        drive(1, 5'b00000, 0, 0, 0, 0);
        outs("reset", 5'b00000, 5'b11111, 0, 2'b00, 0);

        drive(0, 5'b00000, 0, 0, 0, 0);
        outs("idle", 5'b00000, 5'b00000, 0, 2'b00, 0);

        for (int c = 0; c < 3; c++) begin
            drive(0, 5'b01000, 0, 0, 0, 0);
            outs("backpr", 5'b01111, 5'b10000, 0, 2'b00, 0);
        end

        drive(0, 5'b00000, 1, 0, 0, 0);
        outs("ld0", 5'b00011, 5'b00100, 0, 2'b00, 0);
        drive(0, 5'b00000, 0, 0, 0, 0);
        outs("ld1", 5'b00011, 5'b00100, 0, 2'b00, 0);
        drive(0, 5'b00000, 0, 0, 0, 0);
        outs("ld2", 5'b00011, 5'b00100, 0, 2'b00, 0);
        drive(0, 5'b00000, 0, 0, 0, 0);
        outs("ld3", 5'b00000, 5'b00000, 0, 2'b00, 0);

        drive(0, 5'b00000, 0, 1, 1, 0);
        outs("brjp", 5'b00000, 5'b00010, 1, 2'b01, 0);
        drive(0, 5'b00000, 0, 0, 1, 0);
        outs("jump", 5'b00000, 5'b00010, 1, 2'b10, 0);
        drive(0, 5'b00100, 0, 1, 0, 0);
        outs("br_exstall", 5'b00111, 5'b01000, 0, 2'b00, 0);

        drive(0, 5'b00000, 1, 1, 0, 0);
        outs("br_over_ld", 5'b00000, 5'b00010, 1, 2'b01, 0);
        drive(0, 5'b00000, 0, 0, 0, 0);
        outs("br_over_ld+1", 5'b00000, 5'b00000, 0, 2'b00, 0);

        drive(0, 5'b00100, 1, 0, 0, 0);
        outs("ld_exstall", 5'b00111, 5'b01000, 0, 2'b00, 0);
        drive(0, 5'b00000, 0, 0, 0, 0);
        outs("ld_exstall+1", 5'b00000, 5'b00000, 0, 2'b00, 0);

        drive(0, 5'b01000, 0, 0, 0, 1);
        outs("exc0", 5'b01111, 5'b10000, 0, 2'b00, 0);
        for (int c = 1; c < 4; c++) begin
            drive(0, 5'b01000, 0, 1, 0, 1);
            outs("drain", 5'b01111, 5'b10000, 0, 2'b00, 1);
        end
        drive(0, 5'b00000, 1, 0, 0, 1);
        outs("drain_last", 5'b00111, 5'b01000, 0, 2'b00, 1);
        drive(0, 5'b00000, 0, 0, 0, 1);
        outs("trap_redir", 5'b00000, 5'b01111, 1, 2'b11, 1);
        drive(0, 5'b00000, 0, 0, 0, 0);
        outs("trap_done", 5'b00000, 5'b00000, 0, 2'b00, 0);

        drive(0, 5'b00000, 1, 0, 0, 1);
        outs("exc_nodrain", 5'b00000, 5'b00000, 0, 2'b00, 0);
        drive(0, 5'b00000, 1, 1, 0, 1);
        outs("redir_ign", 5'b00000, 5'b01111, 1, 2'b11, 1);
        drive(0, 5'b00000, 0, 0, 0, 0);
        outs("redir_ign+1", 5'b00000, 5'b00000, 0, 2'b00, 0);

        drive(0, 5'b01000, 0, 0, 0, 1);
        drive(0, 5'b01000, 0, 0, 0, 1);
        outs("rst_pre", 5'b01111, 5'b10000, 0, 2'b00, 1);
        drive(1, 5'b01000, 0, 0, 0, 1);
        outs("rst_drain", 5'b00000, 5'b11111, 0, 2'b00, 0);
        drive(1, 5'b00000, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            drive(0, 5'b00000, 0, 0, 0, 0);
            outs("post_rst", 5'b00000, 5'b00000, 0, 2'b00, 0);
        end

`ifdef MORTY_PIPE_PERF_CNT_EN
        @(negedge clk);
        dut.flush_cnt_q = 32'hFFFF_FFFF;
        drive(0, 5'b00000, 0, 1, 0, 0);
        drive(0, 5'b00000, 0, 0, 0, 0);
        chk("flush_wrap", flush_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
